// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched: run-control scheduler for the RV32IMF core.
// Generates a registered clock-enable (CPU_CE) from CLK_50 in one of four
// run modes: halt, full-rate run, divided slow run and debounced single-step.
// SLOW-mode mode/divisor changes are deferred to the period boundary so the
// core never sees a truncated or doubled enable.
// Optional feature macro: CLK_SCHED_CE_COUNT_EN enables the 32-bit CE_COUNT
// pulse counter; when undefined CE_COUNT is tied to zero.
module cpu_clk_sched #(
  parameter int DIV_W        = 28,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic             CLK_50,
  input  logic             RST_N,
  input  logic [1:0]       MODE,
  input  logic [DIV_W-1:0] DIV,
  input  logic             STEP_BTN,
  input  logic             HALT_REQ,
  output logic             CPU_CE,
  output logic             LED_TICK,
  output logic [1:0]       STATE,
  output logic [31:0]      CE_COUNT
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_SLOW = 2'b10,
    S_STEP = 2'b11
  } state_t;

  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  // Synchronizer stages
  logic [1:0]       mode_meta_q, mode_meta_d;
  logic [1:0]       mode_sync_q, mode_sync_d;
  logic             btn_meta_q, btn_meta_d;
  logic             btn_sync_q, btn_sync_d;

  // Debouncer
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_level_q, deb_level_d;
  logic             step_q, step_d;

  // Run-control state and SLOW period counter
  state_t           state_q, state_d;
  state_t           mode_s;
  logic [DIV_W-1:0] per_cnt_q, per_cnt_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [DIV_W-1:0] div_in_s;
  logic             wrap_s;

  // Outputs
  logic             ce_q, ce_d;
  logic             ce_pre_s;
  logic             led_q, led_d;

  // Synchronizer next values: plain two-stage shift of the async inputs
  always_comb begin
    mode_meta_d = MODE;
    mode_sync_d = mode_meta_q;
    btn_meta_d  = STEP_BTN;
    btn_sync_d  = btn_meta_q;
  end

  // Debouncer: count consecutive cycles the button disagrees with the level
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    deb_level_d = deb_level_q;
    step_d      = 1'b0;
    if (btn_sync_q == deb_level_q) begin
      deb_cnt_d = {DEB_W{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d   = {DEB_W{1'b0}};
      deb_level_d = btn_sync_q;
      step_d      = btn_sync_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  // State and period counter: SLOW only moves on at its wrap boundary
  always_comb begin
    mode_s    = state_t'(mode_sync_q);
    div_in_s  = (DIV == DIV_ZERO) ? DIV_ONE : DIV;
    wrap_s    = (state_q == S_SLOW) && (per_cnt_q == (div_l_q - DIV_ONE));
    state_d   = state_q;
    per_cnt_d = DIV_ZERO;
    div_l_d   = div_l_q;
    if (state_q == S_SLOW) begin
      if (wrap_s) begin
        per_cnt_d = DIV_ZERO;
        div_l_d   = div_in_s;
        state_d   = mode_s;
      end else begin
        per_cnt_d = per_cnt_q + DIV_ONE;
      end
    end else begin
      per_cnt_d = DIV_ZERO;
      if (mode_s != state_q) begin
        state_d = mode_s;
      end else begin
        state_d = state_q;
      end
      // Entering SLOW: latch the divisor for the first period
      if (mode_s == S_SLOW) begin
        div_l_d = div_in_s;
      end else begin
        div_l_d = div_l_q;
      end
    end
  end

  // Clock-enable decode from the current state; HALT_REQ overrides everything
  always_comb begin
    case (state_q)
      S_RUN:   ce_pre_s = 1'b1;
      S_SLOW:  ce_pre_s = wrap_s;
      S_STEP:  ce_pre_s = step_q;
      S_HALT:  ce_pre_s = 1'b0;
      default: ce_pre_s = 1'b0;
    endcase
    if (HALT_REQ) begin
      ce_d = 1'b0;
    end else begin
      ce_d = ce_pre_s;
    end
    led_d = led_q ^ ce_d;
  end

  // Main register bank with synchronous active-low reset
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      mode_meta_q <= 2'b00;
      mode_sync_q <= 2'b00;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      deb_cnt_q   <= {DEB_W{1'b0}};
      deb_level_q <= 1'b0;
      step_q      <= 1'b0;
      state_q     <= S_HALT;
      per_cnt_q   <= DIV_ZERO;
      div_l_q     <= DIV_ONE;
      ce_q        <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      mode_meta_q <= mode_meta_d;
      mode_sync_q <= mode_sync_d;
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
      step_q      <= step_d;
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      div_l_q     <= div_l_d;
      ce_q        <= ce_d;
      led_q       <= led_d;
    end
  end

`ifdef CLK_SCHED_CE_COUNT_EN
  logic [31:0] ce_count_q, ce_count_d;

  // Pulse counter next value: wraps naturally at 32 bits
  always_comb begin
    if (ce_d) begin
      ce_count_d = ce_count_q + 32'd1;
    end else begin
      ce_count_d = ce_count_q;
    end
  end

  // Pulse counter register, cleared only by reset
  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      ce_count_q <= 32'd0;
    end else begin
      ce_count_q <= ce_count_d;
    end
  end

  assign CE_COUNT = ce_count_q;
`else
  assign CE_COUNT = 32'd0;
`endif

  assign CPU_CE   = ce_q;
  assign LED_TICK = led_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Testbench for cpu_clk_sched: directed scenarios plus randomized traffic,
// all checked every cycle by a scoreboard fed from an event-time model.
module tb_cpu_clk_sched;

  localparam int DIV_W = 28;
  localparam int DEB   = 4;

  logic             CLK_50 = 1'b0;
  logic             RST_N;
  logic [1:0]       MODE;
  logic [DIV_W-1:0] DIV;
  logic             STEP_BTN;
  logic             HALT_REQ;
  logic             CPU_CE;
  logic             LED_TICK;
  logic [1:0]       STATE;
  logic [31:0]      CE_COUNT;

  always #5 CLK_50 = ~CLK_50;

  cpu_clk_sched #(.DIV_W(DIV_W), .DEBOUNCE_CYC(DEB)) dut (
    .CLK_50(CLK_50), .RST_N(RST_N), .MODE(MODE), .DIV(DIV),
    .STEP_BTN(STEP_BTN), .HALT_REQ(HALT_REQ), .CPU_CE(CPU_CE),
    .LED_TICK(LED_TICK), .STATE(STATE), .CE_COUNT(CE_COUNT)
  );

  typedef struct packed {
    logic        ce;
    logic        led;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // ---------------- reference model (event-time based) ----------------
  int          m_edge = 0;
  logic [1:0]  m_state;
  logic [1:0]  m_h1, m_h2;       // MODE samples from 1 and 2 edges ago
  logic        m_b1, m_b2;       // STEP_BTN samples from 1 and 2 edges ago
  logic        m_level, m_strobe;
  int          m_run;
  int          m_pulse_at;       // absolute edge of the next SLOW pulse
  logic        m_led;
  logic [31:0] m_cnt;

  function automatic int eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? 1 : int'(d);
  endfunction

  task automatic model_edge();
    logic       ce;
    logic [1:0] mode_seen;
    logic       btn_seen;
    logic       strobe_new;
    exp_t       e;
    m_edge++;
    if (!RST_N) begin
      m_state = 2'd0; m_h1 = 2'd0; m_h2 = 2'd0; m_b1 = 1'b0; m_b2 = 1'b0;
      m_level = 1'b0; m_strobe = 1'b0; m_run = 0; m_led = 1'b0; m_cnt = 32'd0;
      ce = 1'b0;
    end else begin
      mode_seen = m_h2;
      btn_seen  = m_b2;
      case (m_state)
        2'd1:    ce = 1'b1;
        2'd2:    ce = (m_edge == m_pulse_at);
        2'd3:    ce = m_strobe;
        default: ce = 1'b0;
      endcase
      if (HALT_REQ) ce = 1'b0;
      if (m_state == 2'd2) begin
        if (m_edge == m_pulse_at) begin
          if (mode_seen != 2'd2) m_state = mode_seen;
          else m_pulse_at = m_edge + eff_div(DIV);
        end
      end else if (mode_seen != m_state) begin
        m_state = mode_seen;
        if (m_state == 2'd2) m_pulse_at = m_edge + eff_div(DIV);
      end
      strobe_new = 1'b0;
      if (btn_seen != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = btn_seen; m_run = 0; strobe_new = btn_seen;
        end
      end else begin
        m_run = 0;
      end
      m_strobe = strobe_new;
      m_h2 = m_h1; m_h1 = MODE;
      m_b2 = m_b1; m_b1 = STEP_BTN;
      m_led = m_led ^ ce;
      if (ce) m_cnt = m_cnt + 32'd1;
    end
    e.ce = ce; e.led = m_led; e.st = m_state;
`ifdef CLK_SCHED_CE_COUNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 32'd0;
`endif
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge CLK_50);
    model_edge();
  end

  // ---------------- monitor ----------------
  int mon_n = 0;
  initial forever begin
    exp_t e;
    @(negedge CLK_50);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mon_n++;
      checks++;
      if ({CPU_CE, LED_TICK, STATE, CE_COUNT} !== e) begin
        errors++;
        $display("FAIL scoreboard edge %0d: got ce=%b led=%b st=%0d cnt=%0d, expected ce=%b led=%b st=%0d cnt=%0d",
                 mon_n, CPU_CE, LED_TICK, STATE, CE_COUNT, e.ce, e.led, e.st, e.cnt);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic next_pulse(output int gap);
    gap = 0;
    do begin
      tick(1);
      gap++;
    end while (CPU_CE !== 1'b1 && gap < 64);
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      tick(1);
      if (CPU_CE === 1'b1) pulses++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   g;
    int   p;
    logic led0;
    logic [31:0] exp10;
`ifdef CLK_SCHED_CE_COUNT_EN
    exp10 = 32'd10;
`else
    exp10 = 32'd0;
`endif
    RST_N = 1'b0; MODE = 2'b01; DIV = 28'd1; STEP_BTN = 1'b0; HALT_REQ = 1'b0;
    tick(5);
    chk("reset_ce", {31'd0, CPU_CE}, 32'd0);
    chk("reset_state", {30'd0, STATE}, 32'd0);
    chk("reset_led", {31'd0, LED_TICK}, 32'd0);
    chk("reset_count", CE_COUNT, 32'd0);

    // RUN from reset
    RST_N = 1'b1;
    tick(2);
    chk("run_state_edge2", {30'd0, STATE}, 32'd0);
    tick(1);
    chk("run_state_edge3", {30'd0, STATE}, 32'd1);
    chk("run_ce_edge3", {31'd0, CPU_CE}, 32'd0);
    tick(1);
    chk("run_ce_edge4", {31'd0, CPU_CE}, 32'd1);
    tick(9);
    chk("run_count10", CE_COUNT, exp10);

    // SLOW with DIV=5
    MODE = 2'b10; DIV = 28'd5;
    tick(3);
    chk("slow_state", {30'd0, STATE}, 32'd2);
    next_pulse(g);
    chk("slow_first_gap", g, 32'd5);
    led0 = LED_TICK;
    next_pulse(g);
    chk("slow_gap5", g, 32'd5);
    chk("slow_led_toggle", {31'd0, LED_TICK}, {31'd0, ~led0});

    // DIV 5 -> 3 two cycles after a pulse
    tick(2);
    DIV = 28'd3;
    next_pulse(g);
    chk("div_change_finish", g, 32'd3);
    next_pulse(g);
    chk("div_change_new", g, 32'd3);

    // DIV = 0 behaves as 1
    DIV = 28'd0;
    next_pulse(g);
    chk("div0_finish", g, 32'd3);
    next_pulse(g);
    chk("div0_gap_a", g, 32'd1);
    next_pulse(g);
    chk("div0_gap_b", g, 32'd1);

    // MODE 10 -> 01 mid-period waits for the wrap
    DIV = 28'd5;
    next_pulse(g);
    tick(1);
    MODE = 2'b01;
    tick(3);
    chk("mode_hold_slow", {30'd0, STATE}, 32'd2);
    next_pulse(g);
    chk("mode_wrap_gap", g, 32'd1);
    chk("mode_now_run", {30'd0, STATE}, 32'd1);
    tick(1);
    chk("mode_run_ce", {31'd0, CPU_CE}, 32'd1);

    // STEP with glitches then a stable press
    MODE = 2'b11;
    tick(4);
    chk("step_state", {30'd0, STATE}, 32'd3);
    STEP_BTN = 1'b1; count_pulses(1, p); g = p;
    STEP_BTN = 1'b0; count_pulses(3, p); g += p;
    STEP_BTN = 1'b1; count_pulses(2, p); g += p;
    STEP_BTN = 1'b0; count_pulses(4, p); g += p;
    chk("step_glitch_none", g, 32'd0);
    STEP_BTN = 1'b1;
    next_pulse(g);
    chk("step_latency", g, 32'd7);
    count_pulses(3, p);
    chk("step_single", p, 32'd0);
    STEP_BTN = 1'b0;
    count_pulses(10, p);
    chk("step_release_none", p, 32'd0);
    STEP_BTN = 1'b1;
    next_pulse(g);
    chk("step_second", g, 32'd7);
    tick(5);
    STEP_BTN = 1'b0;
    tick(10);

    // Press while in RUN is dropped, not queued
    MODE = 2'b01;
    tick(4);
    STEP_BTN = 1'b1;
    tick(12);
    STEP_BTN = 1'b0;
    MODE = 2'b11;
    tick(4);
    count_pulses(10, p);
    chk("step_in_run_dropped", p, 32'd0);

    // HALT_REQ override in RUN
    MODE = 2'b01;
    tick(4);
    chk("halt_pre_ce", {31'd0, CPU_CE}, 32'd1);
    HALT_REQ = 1'b1;
    tick(1);
    chk("halt_ce0", {31'd0, CPU_CE}, 32'd0);
    count_pulses(5, p);
    chk("halt_no_pulse", p, 32'd0);
    HALT_REQ = 1'b0;
    tick(1);
    chk("halt_release_ce", {31'd0, CPU_CE}, 32'd1);

    // Step strobe coinciding with HALT_REQ is dropped
    MODE = 2'b11;
    tick(4);
    STEP_BTN = 1'b1;
    tick(5);
    HALT_REQ = 1'b1;
    count_pulses(4, p);
    HALT_REQ = 1'b0;
    count_pulses(6, g);
    chk("step_halt_dropped", p + g, 32'd0);
    STEP_BTN = 1'b0;
    tick(8);

    // Reset in the middle of a SLOW period
    MODE = 2'b10; DIV = 28'd8;
    tick(4);
    next_pulse(g);
    tick(6);
    RST_N = 1'b0;
    tick(3);
    chk("rst_mid_ce", {31'd0, CPU_CE}, 32'd0);
    chk("rst_mid_led", {31'd0, LED_TICK}, 32'd0);
    chk("rst_mid_state", {30'd0, STATE}, 32'd0);
    chk("rst_mid_count", CE_COUNT, 32'd0);
    RST_N = 1'b1;
    tick(3);
    chk("rst_slow_state", {30'd0, STATE}, 32'd2);
    next_pulse(g);
    chk("rst_slow_gap", g, 32'd8);

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) MODE = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) DIV = DIV_W'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) HALT_REQ = ~HALT_REQ;
      if ($urandom_range(0, 5) == 0) STEP_BTN = ~STEP_BTN;
      if ($urandom_range(0, 599) == 0) RST_N = 1'b0;
      else if (!RST_N && $urandom_range(0, 1) == 0) RST_N = 1'b1;
      tick(1);
    end
    RST_N = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
